mode_transition_manager: RTL and testbench
==========================================

// Module: mode_transition_manager
// PURPOSE
// - Owns current_mode for the hood; consumes the level-held toggle requests from the per-mode controllers (first/second/third/clean/stand) and the power key.
// - Arbitrates simultaneous requests, enforces legal transitions, runs the THIRD and CLEAN mode timers, and reports every mode change.
// - Its current_mode output feeds back to the controllers, which clear their toggle once the mode has left STAND_MODE.
// PARAMETERS
// - MODE_WIDTH    3     width of the mode code
// - OFF_MODE      0     mode code: hood off
// - STAND_MODE    1     mode code: powered, fan idle
// - FIRST_MODE    2     mode code: fan gear 1
// - SECOND_MODE   3     mode code: fan gear 2
// - THIRD_MODE    4     mode code: fan gear 3 (timed burst)
// - CLEAN_MODE    5     mode code: self-clean (timed)
// - TIMER_WIDTH   32    width of the countdown timer
// - THIRD_CYCLES  32'd60_000_000   clock cycles spent in THIRD_MODE (>=1)
// - CLEAN_CYCLES  32'd180_000_000  clock cycles spent in CLEAN_MODE (>=1)
// PORTS
// - clk                 in   1            system clock
// - rstn                in   1            asynchronous reset, active low
// - power_signal        in   1            power key level; rising edge is the event
// - req_first           in   1            first-gear toggle, level-held; rising edge is the event
// - req_second          in   1            second-gear toggle
// - req_third           in   1            third-gear toggle
// - req_clean           in   1            self-clean toggle
// - req_stand           in   1            return-to-standby toggle
// - current_mode        out  MODE_WIDTH   registered mode code
// - mode_changed        out  1            one-cycle pulse in the cycle current_mode takes a new value
// - timer_remaining     out  TIMER_WIDTH  cycles left in THIRD/CLEAN after this one; 0 in other modes
// - third_used          out  1            THIRD_MODE already entered in this power session
// BEHAVIOUR
// - Reset (async): current_mode=OFF_MODE, mode_changed=0, timer_remaining=0, third_used=0, all edge-detect flops=0.
// - Edge detect: each input has a _d flop. An event is in && !in_d. A request already high out of reset is not an event.
// - Latency: an event sampled at edge N updates current_mode, mode_changed and the timer at edge N+1. Exactly one transition per cycle.
// - Priority, highest first: power > req_stand > timer expiry > req_clean > req_third > req_second > req_first.
//   - A lower-priority event in the same cycle is discarded, not queued.
// - Power event:
//   - OFF -> STAND.
//   - Any other mode -> OFF, including aborting a CLEAN or THIRD mid-timer. The timer clears to 0.
// - Transition table (any event not listed is ignored):
//   - OFF: power only.
//   - STAND: req_first->FIRST, req_second->SECOND, req_clean->CLEAN.
//     - req_third->THIRD only if third_used==0. Otherwise it is ignored.
//   - FIRST: req_second->SECOND, req_third->THIRD (same third_used rule), req_stand->STAND. req_first is ignored.
//   - SECOND: req_first->FIRST, req_third->THIRD (same third_used rule), req_stand->STAND.
//   - THIRD: req_stand->STAND. Gear and clean requests are ignored. Timer expiry->SECOND.
//   - CLEAN: all requests are ignored except power. Timer expiry->STAND.
// - Timer:
//   - On entry to THIRD or CLEAN, timer_remaining loads CYCLES-1.
//   - It decrements once per cycle while in that mode.
//   - In the cycle it reads 0, expiry is raised, so the mode lasts exactly CYCLES cycles.
//   - On leaving by any path, timer_remaining is 0 in the first cycle of the new mode.
// - third_used:
//   - Set in the cycle THIRD is entered.
//   - Cleared only when entering OFF.
// - mode_changed: asserted only when the new code differs from the old one. There are no self-transitions.
// - Unknown mode code (corruption): next edge forces OFF_MODE with mode_changed=1.
// TESTING (THIRD_CYCLES=8, CLEAN_CYCLES=12)
// - Reset with req_first held high, then power edge -> STAND with one mode_changed pulse. The held req_first causes no FIRST until it falls and rises again.
// - STAND, req_third edge -> THIRD one cycle later. timer_remaining counts 7..0 over 8 cycles, then SECOND. A second req_third edge in STAND is ignored.
// - STAND, req_clean edge -> CLEAN. req_first/req_stand edges mid-clean are ignored. After 12 cycles -> STAND with one mode_changed pulse.
// - CLEAN at timer_remaining=5, power edge -> OFF next cycle, timer_remaining=0. A following power edge -> STAND with third_used=0.
// - STAND, req_first and req_second rise in the same cycle -> SECOND. In THIRD, req_stand in the expiry cycle -> STAND, not SECOND.
// - Assert rstn low mid-THIRD -> outputs go to reset values immediately, without waiting for clk.

Source files
------------

// File: rtl/mode_transition_manager.sv
// Hood mode manager: edge-detects the controller toggles and the power key,
// arbitrates them by priority, enforces the legal transition table and runs
// the THIRD/CLEAN countdown timers.
module mode_transition_manager #(
   parameter int unsigned                MODE_WIDTH   = 3,
   parameter logic [MODE_WIDTH-1:0]      OFF_MODE     = 3'd0,
   parameter logic [MODE_WIDTH-1:0]      STAND_MODE   = 3'd1,
   parameter logic [MODE_WIDTH-1:0]      FIRST_MODE   = 3'd2,
   parameter logic [MODE_WIDTH-1:0]      SECOND_MODE  = 3'd3,
   parameter logic [MODE_WIDTH-1:0]      THIRD_MODE   = 3'd4,
   parameter logic [MODE_WIDTH-1:0]      CLEAN_MODE   = 3'd5,
   parameter int unsigned                TIMER_WIDTH  = 32,
   parameter logic [TIMER_WIDTH-1:0]     THIRD_CYCLES = 32'd60_000_000,
   parameter logic [TIMER_WIDTH-1:0]     CLEAN_CYCLES = 32'd180_000_000
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   power_signal,
   input  logic                   req_first,
   input  logic                   req_second,
   input  logic                   req_third,
   input  logic                   req_clean,
   input  logic                   req_stand,
   output logic [MODE_WIDTH-1:0]  current_mode,
   output logic                   mode_changed,
   output logic [TIMER_WIDTH-1:0] timer_remaining,
   output logic                   third_used
);

   logic power_d, first_d, second_d, third_d, clean_d, stand_d;
   logic ev_power, ev_first, ev_second, ev_third, ev_clean, ev_stand;
   logic in_timed, expiry, third_ok;

   logic [MODE_WIDTH-1:0]  next_mode;
   logic                   next_changed;
   logic [TIMER_WIDTH-1:0] next_timer;
   logic                   next_third_used;

   assign ev_power  = power_signal & ~power_d;
   assign ev_first  = req_first    & ~first_d;
   assign ev_second = req_second   & ~second_d;
   assign ev_third  = req_third    & ~third_d;
   assign ev_clean  = req_clean    & ~clean_d;
   assign ev_stand  = req_stand    & ~stand_d;

   assign in_timed = (current_mode == THIRD_MODE) || (current_mode == CLEAN_MODE);
   assign expiry   = in_timed && (timer_remaining == '0);
   assign third_ok = ev_third && !third_used;

   // State register: mode, timer, session flag and the edge-detect flops
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         current_mode    <= OFF_MODE;
         mode_changed    <= 1'b0;
         timer_remaining <= '0;
         third_used      <= 1'b0;
         power_d         <= 1'b0;
         first_d         <= 1'b0;
         second_d        <= 1'b0;
         third_d         <= 1'b0;
         clean_d         <= 1'b0;
         stand_d         <= 1'b0;
      end else begin
         current_mode    <= next_mode;
         mode_changed    <= next_changed;
         timer_remaining <= next_timer;
         third_used      <= next_third_used;
         power_d         <= power_signal;
         first_d         <= req_first;
         second_d        <= req_second;
         third_d         <= req_third;
         clean_d         <= req_clean;
         stand_d         <= req_stand;
      end
   end

   // Next mode: within each mode the highest-priority event with a legal
   // target wins; events with no entry for the current mode fall through
   always_comb begin
      next_mode = current_mode;
      case (current_mode)
         OFF_MODE: begin
            if (ev_power) next_mode = STAND_MODE;
         end
         STAND_MODE: begin
            if      (ev_power)  next_mode = OFF_MODE;
            else if (ev_clean)  next_mode = CLEAN_MODE;
            else if (third_ok)  next_mode = THIRD_MODE;
            else if (ev_second) next_mode = SECOND_MODE;
            else if (ev_first)  next_mode = FIRST_MODE;
         end
         FIRST_MODE: begin
            if      (ev_power)  next_mode = OFF_MODE;
            else if (ev_stand)  next_mode = STAND_MODE;
            else if (third_ok)  next_mode = THIRD_MODE;
            else if (ev_second) next_mode = SECOND_MODE;
         end
         SECOND_MODE: begin
            if      (ev_power)  next_mode = OFF_MODE;
            else if (ev_stand)  next_mode = STAND_MODE;
            else if (third_ok)  next_mode = THIRD_MODE;
            else if (ev_first)  next_mode = FIRST_MODE;
         end
         THIRD_MODE: begin
            if      (ev_power)  next_mode = OFF_MODE;
            else if (ev_stand)  next_mode = STAND_MODE;
            else if (expiry)    next_mode = SECOND_MODE;
         end
         CLEAN_MODE: begin
            if      (ev_power)  next_mode = OFF_MODE;
            else if (expiry)    next_mode = STAND_MODE;
         end
         default: next_mode = OFF_MODE;
      endcase
   end

   // Registered-output values: change pulse, timer load/decrement, third_used
   always_comb begin
      next_changed    = (next_mode != current_mode);
      next_timer      = '0;
      next_third_used = third_used;
      if (next_mode == THIRD_MODE || next_mode == CLEAN_MODE) begin
         if (!next_changed)
            next_timer = timer_remaining - 1'b1;
         else if (next_mode == THIRD_MODE)
            next_timer = THIRD_CYCLES - 1'b1;
         else
            next_timer = CLEAN_CYCLES - 1'b1;
      end
      if (next_changed && next_mode == THIRD_MODE) next_third_used = 1'b1;
      if (next_changed && next_mode == OFF_MODE)   next_third_used = 1'b0;
   end

endmodule

// File: tb/tb_mode_transition_manager.sv
// Randomized and directed bench for mode_transition_manager, checked against
// a transition-table reference model with timestamp-based timers.
module tb_mode_transition_manager;

   localparam int T_CYC = 8;
   localparam int C_CYC = 12;
   localparam int M_OFF = 0, M_STAND = 1, M_FIRST = 2, M_SECOND = 3, M_THIRD = 4, M_CLEAN = 5;

   logic        clk = 1'b0;
   logic        rstn;
   logic        pwr, rf, r2, rt, rc, rs;
   logic [2:0]  current_mode;
   logic        mode_changed;
   logic [31:0] timer_remaining;
   logic        third_used;

   int errors = 0;
   int checks = 0;

   // reference model state
   int  m_mode, m_entry, m_cyc;
   bit  m_changed, m_tu;
   bit  m_prev [6];

   mode_transition_manager #(
      .THIRD_CYCLES(32'd8),
      .CLEAN_CYCLES(32'd12)
   ) dut (
      .clk(clk), .rstn(rstn), .power_signal(pwr),
      .req_first(rf), .req_second(r2), .req_third(rt),
      .req_clean(rc), .req_stand(rs),
      .current_mode(current_mode), .mode_changed(mode_changed),
      .timer_remaining(timer_remaining), .third_used(third_used)
   );

   always #5 clk = ~clk;

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
      end
   endtask

   function automatic int m_timer();
      if (m_mode == M_THIRD) return T_CYC - 1 - (m_cyc - m_entry);
      if (m_mode == M_CLEAN) return C_CYC - 1 - (m_cyc - m_entry);
      return 0;
   endfunction

   // event codes in priority order: 0 power,1 stand,2 expiry,3 clean,4 third,5 second,6 first
   function automatic int target(int mode, int ev, bit tu);
      case (mode)
         M_OFF:    if (ev == 0) return M_STAND;
         M_STAND:  case (ev)
                      0: return M_OFF;
                      3: return M_CLEAN;
                      4: if (!tu) return M_THIRD;
                      5: return M_SECOND;
                      6: return M_FIRST;
                      default: ;
                   endcase
         M_FIRST:  case (ev)
                      0: return M_OFF;
                      1: return M_STAND;
                      4: if (!tu) return M_THIRD;
                      5: return M_SECOND;
                      default: ;
                   endcase
         M_SECOND: case (ev)
                      0: return M_OFF;
                      1: return M_STAND;
                      4: if (!tu) return M_THIRD;
                      6: return M_FIRST;
                      default: ;
                   endcase
         M_THIRD:  case (ev)
                      0: return M_OFF;
                      1: return M_STAND;
                      2: return M_SECOND;
                      default: ;
                   endcase
         M_CLEAN:  case (ev)
                      0: return M_OFF;
                      2: return M_STAND;
                      default: ;
                   endcase
         default:  return M_OFF;
      endcase
      return -1;
   endfunction

   task automatic model_reset();
      m_mode = M_OFF; m_changed = 0; m_tu = 0; m_entry = 0; m_cyc = 0;
      for (int i = 0; i < 6; i++) m_prev[i] = 0;
   endtask

   task automatic model_edge();
      bit ins [6];
      bit ev [7];
      int tgt;
      if (!rstn) begin
         model_reset();
      end else begin
         ins[0] = pwr; ins[1] = rs; ins[2] = rc; ins[3] = rt; ins[4] = r2; ins[5] = rf;
         ev[0] = ins[0] && !m_prev[0];
         ev[1] = ins[1] && !m_prev[1];
         ev[2] = (m_mode == M_THIRD || m_mode == M_CLEAN) && (m_timer() == 0);
         ev[3] = ins[2] && !m_prev[2];
         ev[4] = ins[3] && !m_prev[3];
         ev[5] = ins[4] && !m_prev[4];
         ev[6] = ins[5] && !m_prev[5];
         tgt = -1;
         for (int i = 0; i < 7; i++)
            if (ev[i] && tgt < 0) tgt = target(m_mode, i, m_tu);
         m_cyc++;
         if (tgt >= 0 && tgt != m_mode) begin
            m_mode = tgt;
            m_changed = 1;
            if (tgt == M_THIRD || tgt == M_CLEAN) m_entry = m_cyc;
            if (tgt == M_THIRD) m_tu = 1;
            if (tgt == M_OFF) m_tu = 0;
         end else begin
            m_changed = 0;
         end
         for (int i = 0; i < 6; i++) m_prev[i] = ins[i];
      end
   endtask

   task automatic compare();
      check_value("mode",  {29'd0, current_mode}, m_mode);
      check_value("changed", {31'd0, mode_changed}, {31'd0, m_changed});
      check_value("timer", timer_remaining, m_timer());
      check_value("third_used", {31'd0, third_used}, {31'd0, m_tu});
   endtask

   // one clock: model consumes the inputs sampled at the edge, outputs checked 1ns later
   task automatic cycle();
      @(posedge clk);
      model_edge();
      #1;
      compare();
   endtask

   initial begin
      rstn = 1'b1; pwr = 0; rf = 1; r2 = 0; rt = 0; rc = 0; rs = 0;
      #2 rstn = 1'b0;
      #1 model_reset(); compare();
      cycle(); cycle();
      rstn = 1'b1;
      cycle(); cycle();

      // power on with req_first held: STAND, held level is not an event
      pwr = 1; cycle(); pwr = 0;
      check_value("power_on", {29'd0, current_mode}, M_STAND);
      repeat (3) cycle();
      check_value("held_first", {29'd0, current_mode}, M_STAND);
      rf = 0; cycle(); rf = 1; cycle();
      check_value("first_reedge", {29'd0, current_mode}, M_FIRST);
      rf = 0;

      // THIRD burst then automatic fall back to SECOND
      rs = 1; cycle(); rs = 0; cycle();
      rt = 1; cycle(); rt = 0;
      check_value("third_entry_timer", timer_remaining, 32'd7);
      repeat (T_CYC) cycle();
      check_value("third_expiry", {29'd0, current_mode}, M_SECOND);
      rs = 1; cycle(); rs = 0; rt = 1; cycle(); rt = 0; cycle();
      check_value("third_reuse", {29'd0, current_mode}, M_STAND);

      // CLEAN with ignored requests, expiry back to STAND
      rc = 1; cycle(); rc = 0; cycle();
      rf = 1; cycle(); rs = 1; cycle(); rf = 0; rs = 0;
      repeat (C_CYC - 3) cycle();
      check_value("clean_expiry", {29'd0, current_mode}, M_STAND);

      // power abort mid-CLEAN
      rc = 1; cycle(); rc = 0;
      repeat (6) cycle();
      check_value("clean_t5", timer_remaining, 32'd5);
      pwr = 1; cycle(); pwr = 0;
      check_value("abort_off", {29'd0, current_mode}, M_OFF);
      cycle(); pwr = 1; cycle(); pwr = 0;
      check_value("session_third", {31'd0, third_used}, 32'd0);

      // simultaneous gear edges, and stand winning over expiry
      rf = 1; r2 = 1; cycle(); rf = 0; r2 = 0;
      check_value("prio_second", {29'd0, current_mode}, M_SECOND);
      cycle();
      rt = 1; cycle(); rt = 0;
      repeat (T_CYC - 1) cycle();
      rs = 1; cycle(); rs = 0;
      check_value("stand_over_expiry", {29'd0, current_mode}, M_STAND);
      cycle();

      // async reset mid-THIRD
      pwr = 1; cycle(); pwr = 0; cycle();
      pwr = 1; cycle(); pwr = 0; cycle();
      rt = 1; cycle(); rt = 0; cycle(); cycle();
      #2 rstn = 1'b0;
      #1 model_reset(); compare();
      cycle(); cycle();
      rstn = 1'b1;

      // randomized toggling
      repeat (3000) begin
         if ($urandom_range(0, 59) == 0) pwr = ~pwr;
         if ($urandom_range(0, 5) == 0)  rf  = ~rf;
         if ($urandom_range(0, 5) == 0)  r2  = ~r2;
         if ($urandom_range(0, 7) == 0)  rt  = ~rt;
         if ($urandom_range(0, 9) == 0)  rc  = ~rc;
         if ($urandom_range(0, 9) == 0)  rs  = ~rs;
         cycle();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
